// File: rtl/video_pkg.sv
// Shared definitions for the video pattern generator: pattern mode
// encodings, the colour-bar order table and a timing-total helper.
package video_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_RAMP  = 2'd2,
        MODE_CHECK = 2'd3
    } mode_e;

    // Bar colours left to right as {R,G,B} channel-on masks; index 0 is the
    // leftmost bar (white), index 7 the rightmost (black).
    localparam logic [7:0][2:0] BAR_MASK = {
        3'b000,   // 7 black
        3'b001,   // 6 blue
        3'b100,   // 5 red
        3'b101,   // 4 magenta
        3'b010,   // 3 green
        3'b011,   // 2 cyan
        3'b110,   // 1 yellow
        3'b111    // 0 white
    };

    // Total clocks per line (or lines per frame) from its four regions.
    function automatic int calcTotal(input int active, input int fp,
                                     input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_timing.sv
// Raster timing core: horizontal/vertical position counters, the advance
// enable, and the registered de/h/v/frame_start outputs. The current
// position and its decode are exported so the pattern logic can compute the
// pixel that is registered alongside these outputs.
module video_timing
    import video_pkg::*;
#(
    parameter int   H_ACTIVE = 64,
    parameter int   H_FP     = 4,
    parameter int   H_SYNC   = 8,
    parameter int   H_BP     = 4,
    parameter int   V_ACTIVE = 48,
    parameter int   V_FP     = 2,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 2,
    parameter logic SYNC_POL = 1'b1,
    parameter int   HW       = $clog2(calcTotal(H_ACTIVE, H_FP, H_SYNC, H_BP)),
    parameter int   VW       = $clog2(calcTotal(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    output logic [HW-1:0] x_o,
    output logic [VW-1:0] y_o,
    output logic          active_o,
    output logic          frameStartNext_o,
    output logic          de_o,
    output logic          h_o,
    output logic          v_o,
    output logic          frameStart_o
);

    localparam int H_TOTAL = calcTotal(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calcTotal(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END  = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] hCnt_q, hCnt_d;
    logic [VW-1:0] vCnt_q, vCnt_d;
    logic          de_q, h_q, v_q, frameStart_q;
    logic          activeNow, hSyncNow, vSyncNow, frameStartNow;

    // Decode the current position and work out where the raster goes next.
    always_comb begin
        activeNow     = (hCnt_q < H_ACT_END) && (vCnt_q < V_ACT_END);
        hSyncNow      = (hCnt_q >= H_SYNC_BEG) && (hCnt_q < H_SYNC_END);
        vSyncNow      = (vCnt_q >= V_SYNC_BEG) && (vCnt_q < V_SYNC_END);
        frameStartNow = (hCnt_q == '0) && (vCnt_q == '0);
        hCnt_d        = hCnt_q + HW'(1);
        vCnt_d        = vCnt_q;
        if (hCnt_q == H_LAST) begin
            hCnt_d = '0;
            vCnt_d = (vCnt_q == V_LAST) ? '0 : vCnt_q + VW'(1);
        end
    end

    // Register the decoded timing and advance the counters on enabled edges.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hCnt_q       <= '0;
            vCnt_q       <= '0;
            de_q         <= 1'b0;
            h_q          <= ~SYNC_POL;
            v_q          <= ~SYNC_POL;
            frameStart_q <= 1'b0;
        end else if (en_i) begin
            hCnt_q       <= hCnt_d;
            vCnt_q       <= vCnt_d;
            de_q         <= activeNow;
            h_q          <= hSyncNow ? SYNC_POL : ~SYNC_POL;
            v_q          <= vSyncNow ? SYNC_POL : ~SYNC_POL;
            frameStart_q <= frameStartNow;
        end
    end

    assign x_o              = hCnt_q;
    assign y_o              = vCnt_q;
    assign active_o         = activeNow;
    assign frameStartNext_o = frameStartNow;
    assign de_o             = de_q;
    assign h_o              = h_q;
    assign v_o              = v_q;
    assign frameStart_o     = frameStart_q;

endmodule

// File: rtl/video_pattern_gen.sv
// Parametrised video source: real blanking/sync timing plus four selectable
// test patterns (solid, colour bars, ramp, checkerboard). Mode and solid
// colour are captured on pixel (0,0) so a frame never mixes two patterns.
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int   CW       = 8,
    parameter int   H_ACTIVE = 64,
    parameter int   H_FP     = 4,
    parameter int   H_SYNC   = 8,
    parameter int   H_BP     = 4,
    parameter int   V_ACTIVE = 48,
    parameter int   V_FP     = 2,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 2,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic [1:0]      mode_i,
    input  logic [3*CW-1:0] solid_rgb_i,
    output logic [3*CW-1:0] rgb_o,
    output logic            h_o,
    output logic            v_o,
    output logic            de_o,
    output logic            frame_start_o
);

    localparam int HW       = $clog2(calcTotal(H_ACTIVE, H_FP, H_SYNC, H_BP));
    localparam int VW       = $clog2(calcTotal(V_ACTIVE, V_FP, V_SYNC, V_BP));
    localparam int BAR_W    = H_ACTIVE / 8;
    localparam int BW       = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    logic [HW-1:0]   x;
    logic [VW-1:0]   y;
    logic            active;
    logic            frameStartNext;

    logic [BW-1:0]   barCnt_q, barCnt_d, barCntCur;
    logic [2:0]      barIdx_q, barIdx_d, barIdxCur;
    mode_e           modeLat_q, modeCur;
    logic [3*CW-1:0] solidLat_q, solidCur;
    logic [3*CW-1:0] rgb_q, pixel;
    logic [2:0]      barMask;
    logic [CW-1:0]   rampVal;
    logic            unusedY;

    video_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .en_i             (en_i),
        .x_o              (x),
        .y_o              (y),
        .active_o         (active),
        .frameStartNext_o (frameStartNext),
        .de_o             (de_o),
        .h_o              (h_o),
        .v_o              (v_o),
        .frameStart_o     (frame_start_o)
    );

    // Only y[3] drives the checkerboard; the rest of y is deliberately unused.
    assign unusedY = ^y;

    // Bar-width sub-counter: restarts at the left edge, steps the bar index
    // every BAR_W pixels so no divider is needed.
    always_comb begin
        barCntCur = (x == '0) ? '0 : barCnt_q;
        barIdxCur = (x == '0) ? '0 : barIdx_q;
        barCnt_d  = barCntCur + BW'(1);
        barIdx_d  = barIdxCur;
        if (barCntCur == BAR_LAST) begin
            barCnt_d = '0;
            barIdx_d = barIdxCur + 3'd1;
        end
    end

    // Pick the pattern for the current pixel; on pixel (0,0) the live inputs
    // are used directly because they are being latched on this same edge.
    always_comb begin
        modeCur  = frameStartNext ? mode_e'(mode_i) : modeLat_q;
        solidCur = frameStartNext ? solid_rgb_i : solidLat_q;
        barMask  = BAR_MASK[barIdxCur];
        rampVal  = CW'(x);
        pixel    = '0;
        case (modeCur)
            MODE_SOLID: pixel = solidCur;
            MODE_BARS:  pixel = {{CW{barMask[2]}}, {CW{barMask[1]}}, {CW{barMask[0]}}};
            MODE_RAMP:  pixel = {rampVal, rampVal, rampVal};
            MODE_CHECK: pixel = (x[3] ^ y[3]) ? '0 : {(3*CW){1'b1}};
            default:    pixel = '0;
        endcase
    end

    // Register the pixel (blanked outside active video) and the frame latches.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            barCnt_q   <= '0;
            barIdx_q   <= '0;
            modeLat_q  <= MODE_SOLID;
            solidLat_q <= '0;
            rgb_q      <= '0;
        end else if (en_i) begin
            barCnt_q <= barCnt_d;
            barIdx_q <= barIdx_d;
            if (frameStartNext) begin
                modeLat_q  <= modeCur;
                solidLat_q <= solidCur;
            end
            rgb_q <= active ? pixel : '0;
        end
    end

    assign rgb_o = rgb_q;

endmodule

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
- Parametrised, synthesizable video source. Produces RGB pixels with h/v sync and data-enable (de) timing.
- Drives pixel-processing blocks such as rgb2ycbcr in simulation and on hardware.
- Supersedes the fixed single-colour, always-active stimulus with:
  - real blanking and sync intervals;
  - configurable channel width;
  - four selectable test patterns.

Parameters:
- CW, 8, bits per colour channel (rgb is 3*CW wide, packed {R,G,B}).
- H_ACTIVE, 64, active pixels per line (must be a multiple of 8).
- H_FP, 4, horizontal front porch in clocks.
- H_SYNC, 8, horizontal sync width in clocks.
- H_BP, 4, horizontal back porch in clocks.
- V_ACTIVE, 48, active lines per frame (must be at least 16).
- V_FP, 2, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 2, vertical back porch in lines.
- SYNC_POL, 1, asserted level of h and v.

Ports:
- clk  in  1  pixel clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  advance enable; when 0, the generator freezes.
- mode  in  2  pattern select: 0 solid, 1 colour bars, 2 ramp, 3 checkerboard.
- solid_rgb  in  3*CW  colour used in mode 0.
- rgb  out  3*CW  pixel {R,G,B}.
- h  out  1  horizontal sync.
- v  out  1  vertical sync.
- de  out  1  active-video enable.
- frame_start  out  1  single-cycle pulse on pixel (0,0).

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Counters:
  - hcnt runs 0..H_TOTAL-1; vcnt runs 0..V_TOTAL-1.
  - hcnt wraps to 0 and vcnt increments when hcnt = H_TOTAL-1.
  - vcnt wraps to 0 when it is at V_TOTAL-1 and hcnt wraps.
  - Counter widths are $clog2 of the respective total.
- Region order per line/frame: active, front porch, sync, back porch.
- Reset (rst_n=0, asynchronous): hcnt=0, vcnt=0, rgb=0, de=0, h=v=~SYNC_POL, frame_start=0, latched mode=0, latched solid=0.
- All outputs are registered. On each edge with en=1:
  - outputs load values decoded from the current (hcnt,vcnt);
  - the counters then advance.
  - Latency is one clock: the first edge after reset release with en=1 presents pixel (0,0) with de=1 and frame_start=1.
- Decode rules:
  - de = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
  - h = SYNC_POL when H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC; otherwise ~SYNC_POL.
  - v = SYNC_POL when V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC, for whole lines; otherwise ~SYNC_POL.
  - frame_start = (hcnt==0 && vcnt==0).
- Blanking: rgb = 0 whenever de = 0.
- Mode latching:
  - mode and solid_rgb are latched only when hcnt==0 && vcnt==0 && en==1.
  - The latched value applies from pixel (0,0) of that same frame onward.
  - Changes mid-frame take effect at the next frame; there is no tearing.
- Patterns (F = all-ones CW value, x = hcnt, y = vcnt):
  - Mode 0, solid: latched solid_rgb.
  - Mode 1, colour bars: 8 bars, each H_ACTIVE/8 wide, in order white, yellow, cyan, green, magenta, red, blue, black.
    - Channels are F or 0 accordingly, e.g. yellow = {F,F,0}.
    - The bar index comes from a bar-width sub-counter, not a divider. The sub-counter resets at hcnt=0.
  - Mode 2, ramp: R=G=B = x[CW-1:0], truncated (wraps if H_ACTIVE > 2^CW).
  - Mode 3, checkerboard: 8x8 cells; white {F,F,F} if x[3]^y[3] = 0, else black 0.
- en=0:
  - counters, latches and all outputs hold their values;
  - a frame_start that is high stays high until the next enabled edge.
- Reset mid-frame: immediate return to the reset state; restart at pixel (0,0).

Decomposition:
- Package video_pkg:
  - mode encodings MODE_SOLID=0, MODE_BARS=1, MODE_RAMP=2, MODE_CHECK=3;
  - bar colour order table as 3-bit R/G/B-on masks;
  - a function computing the total from active/porch/sync values.
- One sub-module, video_timing:
  - owns hcnt/vcnt, the en gating, and registered de/h/v/frame_start decode;
  - exports x, y, active and frame_start-next to the pattern logic in video_pattern_gen.

Test Plan:
- Reset for 5 clocks, release, en=1, mode=0, solid_rgb=24'h73C841, defaults → first enabled edge: de=1, frame_start=1, rgb=24'h73C841. de high for 64 clocks, then low for 16 clocks. frame_start period = 4320 clocks (80x54).
- Sync timing, defaults → h asserted exactly at hcnt 68..75 of every line. v asserted for lines 50..51, i.e. 160 consecutive clocks per frame. rgb=0 throughout blanking.
- mode=1 → the 8 bars last 8 clocks each in line 0: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. Identical content on line 47.
- mode=2 then mode=3 → ramp: pixel x of every active line = {x,x,x}, e.g. x=63 gives 3F3F3F. Checker: (x=8,y=0) = 000000, (x=8,y=8) = FFFFFF.
- Switch mode 0→1 at line 20 → the remainder of the frame stays solid; bars begin exactly on the next frame_start pixel.
- Drop en for 10 clocks mid-line, then reassert rst_n=0 during active video → all outputs frozen while en=0. On reset: immediately rgb=0, de=0, h=v=0. Restart on the first enabled edge after release with frame_start=1.
